// File: rtl/sel_code_driver.sv
// Round-robin arbiter driving the select bus of a 4-way data-path mux.
// Grants are held for a programmable dwell and followed by a one-cycle idle gap.
module sel_code_driver #(
    parameter int SEL_W   = 260,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_valid,
    output logic [3:0]         grant,
    output logic               done,
    output logic               abort
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [1:0]         ch, ch_d;
    logic [1:0]         ptr, ptr_d;
    logic [DWELL_W-1:0] cnt, cnt_d;
    logic [SEL_W-1:0]   sel_d;
    logic               sel_valid_d;
    logic [3:0]         grant_d;
    logic               done_d;
    logic               abort_d;
    logic               found;
    logic [1:0]         idx;

    function automatic logic [SEL_W-1:0] ch_code(input logic [1:0] c);
        case (c)
            2'd0:    ch_code = '0;
            2'd1:    ch_code = {{(SEL_W-4){1'b0}}, 4'hF};
            2'd2:    ch_code = {{(SEL_W-8){1'b0}}, 8'hFF};
            default: ch_code = {{(SEL_W-16){1'b0}}, 16'hFFFF};
        endcase
    endfunction

    always_comb begin
        state_d = state;
        ch_d    = ch;
        ptr_d   = ptr;
        cnt_d   = cnt;
        done_d  = 1'b0;
        abort_d = 1'b0;
        found   = 1'b0;
        idx     = '0;

        case (state)
            IDLE: begin
                for (int unsigned i = 0; i < 4; i++) begin
                    idx = ptr + 2'(i);
                    if (!found && req[idx]) begin
                        found = 1'b1;
                        ch_d  = idx;
                    end
                end
                if (found) begin
                    cnt_d   = (dwell == '0) ? DWELL_W'(1) : dwell;
                    ptr_d   = ch_d + 2'd1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                cnt_d = cnt - DWELL_W'(1);
                // A dropped request wins over dwell expiry in the same cycle.
                if (!req[ch]) begin
                    state_d = GAP;
                    abort_d = 1'b1;
                end else if (cnt == DWELL_W'(1)) begin
                    state_d = GAP;
                    done_d  = 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they land in registers.
        sel_valid_d = (state_d == HOLD);
        grant_d     = sel_valid_d ? (4'b0001 << ch_d) : '0;
        sel_d       = sel_valid_d ? ch_code(ch_d) : '1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ch        <= '0;
            ptr       <= '0;
            cnt       <= '0;
            sel       <= '1;
            sel_valid <= 1'b0;
            grant     <= '0;
            done      <= 1'b0;
            abort     <= 1'b0;
        end else begin
            state     <= state_d;
            ch        <= ch_d;
            ptr       <= ptr_d;
            cnt       <= cnt_d;
            sel       <= sel_d;
            sel_valid <= sel_valid_d;
            grant     <= grant_d;
            done      <= done_d;
            abort     <= abort_d;
        end
    end

endmodule

// File: tb/tb_sel_code_driver.sv
// Directed bench for sel_code_driver: reset, dwell, rotation, abort and
// mid-grant reset scenarios with hand-computed expectations.
module tb_sel_code_driver;

    localparam int SEL_W   = 260;
    localparam int DWELL_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [3:0]         req;
    logic [DWELL_W-1:0] dwell;
    logic [SEL_W-1:0]   sel;
    logic               sel_valid;
    logic [3:0]         grant;
    logic               done;
    logic               abort;

    int checks = 0;
    int errors = 0;

    logic [SEL_W-1:0] code [4];
    logic [SEL_W-1:0] idle_code;

    sel_code_driver #(
        .SEL_W   (SEL_W),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .dwell     (dwell),
        .sel       (sel),
        .sel_valid (sel_valid),
        .grant     (grant),
        .done      (done),
        .abort     (abort)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [SEL_W-1:0] obs, input logic [SEL_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_out(input string tag, input logic [SEL_W-1:0] s, input logic v,
                           input logic [3:0] g, input logic d, input logic a);
        chk({tag, ".sel"}, sel, s);
        chk({tag, ".sel_valid"}, SEL_W'(sel_valid), SEL_W'(v));
        chk({tag, ".grant"}, SEL_W'(grant), SEL_W'(g));
        chk({tag, ".done"}, SEL_W'(done), SEL_W'(d));
        chk({tag, ".abort"}, SEL_W'(abort), SEL_W'(a));
    endtask

    initial begin
        logic [3:0] g;
        code[0]   = '0;
        code[1]   = {{(SEL_W-4){1'b0}}, 4'hF};
        code[2]   = {{(SEL_W-8){1'b0}}, 8'hFF};
        code[3]   = {{(SEL_W-16){1'b0}}, 16'hFFFF};
        idle_code = '1;

        // Reset held for 3 cycles with all requests active
        rst   = 1'b1;
        req   = 4'hF;
        dwell = 8'd1;
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_out("reset", idle_code, 1'b0, 4'b0000, 1'b0, 1'b0);
        end
        rst = 1'b0;

        // Rotation ch0..ch3, ch0 with dwell 1: grant, gap, idle every 3 cycles
        for (int k = 0; k < 5; k++) begin
            g = 4'b0001 << k[1:0];
            tick();
            exp_out("rr_grant", code[k % 4], 1'b1, g, 1'b0, 1'b0);
            tick();
            exp_out("rr_gap", idle_code, 1'b0, 4'b0000, 1'b1, 1'b0);
            if (k == 4) req = 4'h0;
            tick();
            exp_out("rr_idle", idle_code, 1'b0, 4'b0000, 1'b0, 1'b0);
        end
        tick();
        exp_out("idle_noreq", idle_code, 1'b0, 4'b0000, 1'b0, 1'b0);

        // Single full dwell of 3 on ch2 (ptr is 1)
        req   = 4'b0100;
        dwell = 8'd3;
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_out("dwell3_hold", code[2], 1'b1, 4'b0100, 1'b0, 1'b0);
        end
        tick();
        exp_out("dwell3_gap", idle_code, 1'b0, 4'b0000, 1'b1, 1'b0);
        req = 4'h0;
        tick();
        exp_out("dwell3_idle", idle_code, 1'b0, 4'b0000, 1'b0, 1'b0);

        // Abort: ch3 granted with dwell 10, request drops after 2 HOLD cycles
        req   = 4'b1000;
        dwell = 8'd10;
        tick();
        exp_out("abort_hold1", code[3], 1'b1, 4'b1000, 1'b0, 1'b0);
        tick();
        exp_out("abort_hold2", code[3], 1'b1, 4'b1000, 1'b0, 1'b0);
        req   = 4'b0001;
        dwell = 8'd0;
        tick();
        exp_out("abort_gap", idle_code, 1'b0, 4'b0000, 1'b0, 1'b1);
        tick();
        exp_out("abort_idle", idle_code, 1'b0, 4'b0000, 1'b0, 1'b0);

        // Next grant ch0 with dwell 0, treated as a single HOLD cycle
        tick();
        exp_out("dwell0_hold", code[0], 1'b1, 4'b0001, 1'b0, 1'b0);
        tick();
        exp_out("dwell0_gap", idle_code, 1'b0, 4'b0000, 1'b1, 1'b0);
        req = 4'h0;
        tick();
        exp_out("dwell0_idle", idle_code, 1'b0, 4'b0000, 1'b0, 1'b0);

        // Dwell 5 sampled at grant; later dwell change and extra requests ignored
        req   = 4'b0010;
        dwell = 8'd5;
        tick();
        exp_out("dwchg_hold1", code[1], 1'b1, 4'b0010, 1'b0, 1'b0);
        dwell = 8'd2;
        req   = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_out("dwchg_hold", code[1], 1'b1, 4'b0010, 1'b0, 1'b0);
        end
        tick();
        exp_out("dwchg_gap", idle_code, 1'b0, 4'b0000, 1'b1, 1'b0);
        req = 4'h0;
        tick();
        exp_out("dwchg_idle", idle_code, 1'b0, 4'b0000, 1'b0, 1'b0);

        // Reset on the 2nd cycle of a 4-cycle grant on ch2 (ptr is 2)
        req   = 4'b0100;
        dwell = 8'd4;
        tick();
        exp_out("rsthold_hold1", code[2], 1'b1, 4'b0100, 1'b0, 1'b0);
        tick();
        exp_out("rsthold_hold2", code[2], 1'b1, 4'b0100, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        exp_out("rsthold_reset", idle_code, 1'b0, 4'b0000, 1'b0, 1'b0);
        rst   = 1'b0;
        req   = 4'hF;
        dwell = 8'd1;
        tick();
        exp_out("rsthold_ptr0", code[0], 1'b1, 4'b0001, 1'b0, 1'b0);

        // Request drop on the final dwell cycle: abort takes priority over done
        req = 4'b1110;
        tick();
        exp_out("prio_gap", idle_code, 1'b0, 4'b0000, 1'b0, 1'b1);
        req = 4'h0;
        tick();
        exp_out("prio_idle", idle_code, 1'b0, 4'b0000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
